// File: rtl/sipo_rx_ctrl.sv
// Frame controller for a one-bit-per-clock serial line feeding an N-bit SIPO.
// Optional even-parity checking is compiled in with `define SIPO_RX_PARITY_EN.
module sipo_rx_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic [N-1:0] sipo_pout,
  output logic         sipo_shift_en,
  output logic [N-1:0] word,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  // Handshake: word is held stable while word_valid is high; a transfer
  // completes on any rising edge where word_valid && word_ready.

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] bit_cnt;
  logic          parity_ok;
  logic          good;
  logic          load;

`ifdef SIPO_RX_PARITY_EN
  logic parity_acc;
  logic parity_ok_q;
  assign parity_ok = parity_ok_q;
`else
  assign parity_ok = 1'b1;
`endif

  assign good = (state == STOP) && sin && parity_ok;
  // A good frame may replace a word that is being consumed on the same edge.
  assign load = good && (!word_valid || word_ready);

  always_comb begin
    next_state    = state;
    sipo_shift_en = (state == DATA);
    busy          = (state != IDLE);
    state_dbg     = state;
    case (state)
      IDLE: if (!sin) next_state = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
`ifdef SIPO_RX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
      PARITY:  next_state = STOP;
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      word        <= '0;
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      parity_acc  <= 1'b0;
      parity_ok_q <= 1'b0;
`endif
    end else begin
      state     <= next_state;
      frame_err <= (state == STOP) && !good;
      overrun   <= good && !load;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
`ifdef SIPO_RX_PARITY_EN
          parity_acc <= 1'b0;
`endif
        end
        DATA: begin
          bit_cnt <= bit_cnt + 1'b1;
`ifdef SIPO_RX_PARITY_EN
          parity_acc <= parity_acc ^ sin;
`endif
        end
`ifdef SIPO_RX_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to zero.
        PARITY: parity_ok_q <= ~(parity_acc ^ sin);
`endif
        default: ;
      endcase
      if (load) begin
        word       <= sipo_pout;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl with a companion SIPO and a word scoreboard.
// Build with +define+SIPO_RX_PARITY_EN to exercise the parity variant.
module tb_sipo_rx_ctrl;
  localparam int N = 8;
`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME_LEN = N + 3;
`else
  localparam int FRAME_LEN = N + 2;
`endif

  logic         clk;
  logic         rst;
  logic         sin;
  logic [N-1:0] sipo_pout;
  logic         sipo_shift_en;
  logic [N-1:0] word;
  logic         word_valid;
  logic         word_ready;
  logic         frame_err;
  logic         overrun;
  logic         busy;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_shift = 0, n_valid = 0, n_ferr = 0, n_ovr = 0, n_hs = 0;
  int last_hs = 0, prev_hs = 0;
  logic [N-1:0] exp_q[$];

  sipo_rx_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sipo_pout(sipo_pout),
    .sipo_shift_en(sipo_shift_en), .word(word), .word_valid(word_valid),
    .word_ready(word_ready), .frame_err(frame_err), .overrun(overrun),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Companion SIPO: shifts toward MSB so the first data bit ends in bit N-1.
  always @(posedge clk) begin
    if (sipo_shift_en) sipo_pout <= {sipo_pout[N-2:0], sin};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: sampled on the falling edge, away from input changes.
  always @(negedge clk) begin
    if (!rst) begin
      if (sipo_shift_en) n_shift++;
      if (frame_err)     n_ferr++;
      if (overrun)       n_ovr++;
      if (word_valid)    n_valid++;
      if (word_valid && word_ready) begin
        n_hs++;
        prev_hs = last_hs;
        last_hs = cyc;
        if (exp_q.size() == 0) chk("unexpected_word", {24'd0, word}, 32'hFFFF_FFFF);
        else                   chk("word", {24'd0, word}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop_b, input logic par_b);
    drive_bit(1'b0);
    for (int i = N - 1; i >= 0; i--) drive_bit(d[i]);
`ifdef SIPO_RX_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b) ; // parity bit not transmitted in this build
`endif
    drive_bit(stop_b);
  endtask

  function automatic logic even_par(input logic [N-1:0] d);
    return ^d;
  endfunction

  int s_shift, s_valid, s_ferr, s_ovr;
  task automatic snap();
    s_shift = n_shift; s_valid = n_valid; s_ferr = n_ferr; s_ovr = n_ovr;
  endtask

  initial begin
    logic [N-1:0] d;
    logic         stop_b;
    int           wait_cnt;
    rst = 1'b1; sin = 1'b1; word_ready = 1'b1; sipo_pout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", {24'd0, word}, 32'd0);
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_shift_en", {31'd0, sipo_shift_en}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    idle(2);

    // single good frame
    snap();
    exp_q.push_back(8'hB5);
    send_frame(8'hB5, 1'b1, even_par(8'hB5));
    idle(3);
    chk("t1_shift_cycles", n_shift - s_shift, N);
    chk("t1_valid_cycles", n_valid - s_valid, 1);
    chk("t1_frame_err", n_ferr - s_ferr, 0);
    chk("t1_overrun", n_ovr - s_ovr, 0);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);

    // back-to-back frames, no idle gap
    snap();
    exp_q.push_back(8'hB5);
    exp_q.push_back(8'h53);
    send_frame(8'hB5, 1'b1, even_par(8'hB5));
    send_frame(8'h53, 1'b1, even_par(8'h53));
    idle(3);
    chk("t2_hs_spacing", last_hs - prev_hs, FRAME_LEN);
    chk("t2_shift_cycles", n_shift - s_shift, 2 * N);
    chk("t2_frame_err", n_ferr - s_ferr, 0);

    // bad stop bit, then a good frame
    snap();
    send_frame(8'hB5, 1'b0, even_par(8'hB5));
    chk("t3_valid_after_bad", {31'd0, word_valid}, 32'd0);
    idle(1);
    exp_q.push_back(8'h53);
    send_frame(8'h53, 1'b1, even_par(8'h53));
    idle(3);
    chk("t3_frame_err", n_ferr - s_ferr, 1);
    chk("t3_valid_cycles", n_valid - s_valid, 1);

    // consumer stalled: second frame overruns
    snap();
    word_ready = 1'b0;
    exp_q.push_back(8'hB5);
    send_frame(8'hB5, 1'b1, even_par(8'hB5));
    send_frame(8'h53, 1'b1, even_par(8'h53));
    idle(2);
    chk("t4_word_held", {24'd0, word}, 32'h0000_00B5);
    chk("t4_valid_held", {31'd0, word_valid}, 32'd1);
    chk("t4_overrun", n_ovr - s_ovr, 1);
    chk("t4_frame_err", n_ferr - s_ferr, 0);
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_valid_clear", {31'd0, word_valid}, 32'd0);
    idle(2);

    // reset after four data bits
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_shift_en", {31'd0, sipo_shift_en}, 32'd0);
    chk("t5_word", {24'd0, word}, 32'd0);
    chk("t5_valid", {31'd0, word_valid}, 32'd0);
    chk("t5_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    snap();
    exp_q.push_back(8'h53);
    send_frame(8'h53, 1'b1, even_par(8'h53));
    idle(3);
    chk("t5_valid_cycles", n_valid - s_valid, 1);

`ifdef SIPO_RX_PARITY_EN
    // parity good, then parity bad
    snap();
    exp_q.push_back(8'hB5);
    send_frame(8'hB5, 1'b1, 1'b1);
    send_frame(8'hB5, 1'b1, 1'b0);
    idle(3);
    chk("t6_frame_err", n_ferr - s_ferr, 1);
    chk("t6_valid_cycles", n_valid - s_valid, 1);
`endif

    // random frames with random gaps and occasional bad stop bits
    snap();
    for (int k = 0; k < 20; k++) begin
      d = N'($urandom_range(0, (1 << N) - 1));
      stop_b = ($urandom_range(0, 4) != 0);
      if (stop_b) exp_q.push_back(d);
      send_frame(d, stop_b, even_par(d));
      idle($urandom_range(0, 2));
    end
    idle(3);
    chk("t7_overrun", n_ovr - s_ovr, 0);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
# sipo_rx_ctrl

Frame controller that sequences the N-bit serial-in/parallel-out shift register on a one-bit-per-clock serial line. It detects a start bit, asserts the SIPO shift enable for exactly N data cycles, checks the stop bit (and optional parity), and hands the captured word downstream over a valid/ready handshake. It sits between the serial input pin and the parallel consumer, with the SIPO datapath as its only controlled resource.

## Interface
- N, 8, data bits per frame (N >= 2); must equal the companion SIPO width
- clk  in  1  rising-edge clock; one serial bit per cycle
- rst  in  1  asynchronous, active-high reset
- sin  in  1  serial line, idle high; also wired to the SIPO serial input
- sipo_pout  in  N  parallel output of the companion SIPO, which shifts toward MSB so the first data bit lands in bit N-1
- sipo_shift_en  out  1  SIPO captures sin on this clock edge
- word  out  N  last good frame
- word_valid  out  1  word holds an unconsumed frame
- word_ready  in  1  consumer accepts word
- frame_err  out  1  one-cycle pulse: bad stop bit (or parity)
- overrun  out  1  one-cycle pulse: good frame dropped because word still held
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DATA, PARITY (only with macro), STOP.
- IDLE: sin==0 sampled -> DATA, bit_cnt=0, parity_acc=0. Otherwise stay.
- DATA: sipo_shift_en=1 (combinational, state==DATA); each edge bit_cnt++, parity_acc^=sin; at bit_cnt==N-1 -> PARITY if enabled, else STOP.
- PARITY: parity_ok <= (parity_acc ^ sin)==0 (even parity over data+parity bit) -> STOP.
- STOP: sample sin; good = sin==1 && parity_ok (parity_ok fixed 1 without macro). Always -> IDLE.
  - good, word_valid==0 or word_ready==1: word<=sipo_pout, word_valid<=1.
  - good, word_valid==1 and word_ready==0: word unchanged, overrun pulses.
  - not good: frame_err pulses, word/word_valid unchanged except normal acceptance.
- Handshake: word stable while word_valid; word_valid clears on edge where word_ready==1, unless a good frame loads on the same edge (then stays 1 with new word, no overrun).
- sipo_shift_en is 0 in every state other than DATA; the SIPO is never cleared, since N shifts overwrite it.
- A start bit is recognised only in IDLE; sin during STOP is the stop bit, not a new start.

## Timing
- Reset values: state IDLE, bit_cnt 0, parity_acc 0, word 0, word_valid 0, frame_err 0, overrun 0, busy 0, sipo_shift_en 0.
- Reset mid-frame: partial frame discarded; outputs return to reset values immediately (async).
- Frame length: 1+N+1 cycles (N+3 with parity); back-to-back frames allowed, start bit may arrive the cycle after STOP.
- word_valid, frame_err, overrun all update on the edge that samples the stop bit; pulses last exactly one cycle.
- word_ready is ignored while word_valid==0.

## Configuration
- SIPO_RX_PARITY_EN defined: PARITY state present; frame carries one even-parity bit after data; parity mismatch or bad stop -> frame_err.
- Not defined: no PARITY state, no parity_acc logic; frame is start + N data + stop; only stop bit checked.

## Test plan
- Reset, word_ready=1, sin frame 0,1,0,1,1,0,1,0,1,1 -> sipo_shift_en high exactly 8 cycles, word=8'hB5, word_valid=1 for one cycle, no errors.
- Back-to-back frames B5 then 53 (0,0,1,0,1,0,0,1,1,1) with no idle gap, word_ready=1 -> word 8'hB5 then 8'h53, 10 cycles apart.
- Frame B5 with stop bit 0 -> frame_err pulse, word_valid stays 0, returns to IDLE and next good frame 53 accepted.
- word_ready=0, frames B5 then 53 -> word stays 8'hB5, word_valid held, overrun pulses on 53's stop edge; raise word_ready -> word_valid clears next edge.
- Assert rst after 4 data bits of a frame -> all outputs reset immediately, busy=0; next full frame 53 received correctly.
- With SIPO_RX_PARITY_EN: B5 + parity 1 + stop -> accepted; B5 + parity 0 + stop -> frame_err, no word_valid.
